// File: rtl/i2s_tx_master.sv
// ----------------------------------------------------------------------------
// i2s_tx_master
// I2S / left-justified stereo transmitter running on the system clock. SCK is
// produced by a clock-enable divider, WS and SD change only on SCK falling
// events, and stereo sample pairs are buffered in a small FIFO.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   en                serial output enable (0 parks the serial side)
//   in_valid/in_ready sample-pair handshake into the FIFO
//   in_left/in_right  two's complement samples, DATA_W bits each
//   sck, ws, sd       serial bit clock, word select (0 = left), data MSB first
//   underrun          one-clk pulse when a frame starts with the FIFO empty
//   fifo_level        current FIFO occupancy
// ----------------------------------------------------------------------------
module i2s_tx_master #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned SLOT_W     = 32,
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FMT        = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_left,
   input  logic [DATA_W-1:0]             in_right,
   output logic                          sck,
   output logic                          ws,
   output logic                          sd,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned FRAME = 2 * SLOT_W;
   localparam int unsigned BW    = $clog2(FRAME);
   localparam int unsigned DVW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned LW    = AW + 1;
   localparam int unsigned PW    = 2 * DATA_W;

   logic [DVW-1:0]    r_div_cnt;
   logic              r_sck;
   logic [BW-1:0]     r_bit_cnt;
   logic              r_ws;
   logic              r_sd;
   logic              r_underrun;
   logic [DATA_W-1:0] r_hold_l;
   logic [DATA_W-1:0] r_hold_r;
   logic [PW-1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              r_in_ready;

   logic              w_div_wrap;
   logic              w_fall;
   logic [BW-1:0]     w_bit_nxt;
   logic [BW-1:0]     w_pos;
   logic              w_load;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [PW-1:0]     w_head;
   logic [DATA_W-1:0] w_hold_l_nxt;
   logic [DATA_W-1:0] w_hold_r_nxt;
   logic              w_right;
   logic [BW-1:0]     w_q;
   logic [DATA_W-1:0] w_sel;
   logic [DATA_W-1:0] w_shift;
   logic              w_ws_nxt;
   logic [LW-1:0]     w_level_nxt;

   assign sck        = r_sck;
   assign ws         = r_ws;
   assign sd         = r_sd;
   assign underrun   = r_underrun;
   assign in_ready   = r_in_ready;
   assign fifo_level = r_level;

   // Falling event: divider wraps while SCK is high.
   assign w_div_wrap = (r_div_cnt == DVW'(CLK_DIV - 1));
   assign w_fall     = en && w_div_wrap && r_sck;
   assign w_bit_nxt  = (r_bit_cnt == BW'(FRAME - 1)) ? '0 : r_bit_cnt + 1'b1;

   // I2S delays the data position by one SCK relative to bit_cnt.
   assign w_pos = (FMT == 1) ? w_bit_nxt :
                  ((w_bit_nxt == '0) ? BW'(FRAME - 1) : w_bit_nxt - 1'b1);

   assign w_ws_nxt = (FMT == 1) ? (w_bit_nxt >= BW'(SLOT_W)) :
                     ((w_bit_nxt >= BW'(SLOT_W - 1)) && (w_bit_nxt <= BW'(FRAME - 2)));

   // Frame load; an empty FIFO loads silence even if a push lands this clk.
   assign w_load  = w_fall && (w_pos == '0);
   assign w_empty = (r_level == '0);
   assign w_push  = in_valid && r_in_ready;
   assign w_pop   = w_load && !w_empty;
   assign w_head  = r_mem[r_rd_ptr];

   assign w_hold_l_nxt = w_load ? (w_empty ? '0 : w_head[PW-1:DATA_W]) : r_hold_l;
   assign w_hold_r_nxt = w_load ? (w_empty ? '0 : w_head[DATA_W-1:0])  : r_hold_r;

   // Shifting left by the slot offset leaves the wanted bit at the MSB and
   // naturally yields zero padding once the offset passes DATA_W.
   assign w_right = (w_pos >= BW'(SLOT_W));
   assign w_q     = w_right ? (w_pos - BW'(SLOT_W)) : w_pos;
   assign w_sel   = w_right ? w_hold_r_nxt : w_hold_l_nxt;
   assign w_shift = w_sel << w_q;

   assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

   // Divider, bit counter and serial outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_cnt  <= '0;
         r_sck      <= 1'b0;
         r_bit_cnt  <= BW'(FRAME - 1);
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
         r_hold_l   <= '0;
         r_hold_r   <= '0;
      end else if (!en) begin
         r_div_cnt  <= '0;
         r_sck      <= 1'b0;
         r_bit_cnt  <= BW'(FRAME - 1);
         r_ws       <= 1'b0;
         r_sd       <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_div_cnt  <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
         if (w_div_wrap) begin
            r_sck <= ~r_sck;
         end
         r_underrun <= w_load && w_empty;
         if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_ws      <= w_ws_nxt;
            r_sd      <= w_shift[DATA_W-1];
            r_hold_l  <= w_hold_l_nxt;
            r_hold_r  <= w_hold_r_nxt;
         end
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_left, in_right};
      end
   end

   // FIFO pointers, occupancy and registered ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_in_ready <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_level    <= w_level_nxt;
         r_in_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
      end
   end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Two transmitter configurations driven by shared stimulus. Each has a
// cycle-count timing model with a scoreboard queue of accepted sample pairs;
// all comparisons happen on the falling clk edge from the single initial block.
module tb_i2s_tx_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_left = '0;
   logic [15:0] in_right = '0;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen
      localparam int SW  = (g == 0) ? 16 : 32;
      localparam int FM  = (g == 0) ? 0 : 1;
      localparam int CD  = 2;
      localparam int DW  = 16;
      localparam int DEP = 4;
      localparam int FR  = 2 * SW;

      logic       sck_o, ws_o, sd_o, und_o, rdy_o;
      logic [2:0] lvl_o;

      i2s_tx_master #(
         .DATA_W(DW), .SLOT_W(SW), .CLK_DIV(CD), .FMT(FM), .FIFO_DEPTH(DEP)
      ) dut (
         .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
         .in_ready(rdy_o), .in_left(in_left), .in_right(in_right),
         .sck(sck_o), .ws(ws_o), .sd(sd_o), .underrun(und_o),
         .fifo_level(lvl_o)
      );

      logic [31:0] fq [$];
      logic [15:0] cur_l, cur_r, sel;
      logic        e_sck, e_ws, e_sd, e_und, push;
      int          k, m, b, p, qq, e_lvl;

      // Expected state after each clk edge, from elapsed enabled cycles.
      always begin
         @(posedge clk);
         #1;
         if (reset) begin
            k = 0; fq.delete(); cur_l = '0; cur_r = '0;
            e_sck = 0; e_ws = 0; e_sd = 0; e_und = 0;
         end else begin
            push  = in_valid && (fq.size() < DEP);
            e_und = 0;
            if (en) begin
               k++;
               e_sck = ((k / CD) % 2) == 1;
               if ((k % (2 * CD)) == 0) begin
                  m = k / (2 * CD);
                  b = (m - 1) % FR;
                  p = (FM == 1) ? b : (b + FR - 1) % FR;
                  if (p == 0) begin
                     if (fq.size() > 0) {cur_l, cur_r} = fq.pop_front();
                     else begin cur_l = '0; cur_r = '0; e_und = 1; end
                  end
                  e_ws = (FM == 1) ? (b >= SW) : (b >= SW - 1 && b <= FR - 2);
                  qq   = p % SW;
                  sel  = (p < SW) ? cur_l : cur_r;
                  e_sd = (qq < DW) ? sel[DW-1-qq] : 1'b0;
               end
            end else begin
               k = 0; e_sck = 0; e_ws = 0; e_sd = 0;
            end
            if (push) fq.push_back({in_left, in_right});
         end
         e_lvl = fq.size();
      end
   end

   task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp_v);
      vecs++;
      assert (obs === exp_v) else begin
         errs++;
         $error("FAIL %s dut%0d: observed %0h expected %0h at %0t", tag, g, obs, exp_v, $time);
      end
   endtask

   task automatic check_all();
      chk("sck",      0, 32'(gen[0].sck_o), 32'(gen[0].e_sck));
      chk("ws",       0, 32'(gen[0].ws_o),  32'(gen[0].e_ws));
      chk("sd",       0, 32'(gen[0].sd_o),  32'(gen[0].e_sd));
      chk("underrun", 0, 32'(gen[0].und_o), 32'(gen[0].e_und));
      chk("level",    0, 32'(gen[0].lvl_o), 32'(gen[0].e_lvl));
      chk("in_ready", 0, 32'(gen[0].rdy_o), 32'(gen[0].e_lvl < 4));
      chk("sck",      1, 32'(gen[1].sck_o), 32'(gen[1].e_sck));
      chk("ws",       1, 32'(gen[1].ws_o),  32'(gen[1].e_ws));
      chk("sd",       1, 32'(gen[1].sd_o),  32'(gen[1].e_sd));
      chk("underrun", 1, 32'(gen[1].und_o), 32'(gen[1].e_und));
      chk("level",    1, 32'(gen[1].lvl_o), 32'(gen[1].e_lvl));
      chk("in_ready", 1, 32'(gen[1].rdy_o), 32'(gen[1].e_lvl < 4));
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         check_all();
      end
   endtask

   logic [15:0] lt [5] = '{16'hA5C3, 16'h8001, 16'h1234, 16'hFFFF, 16'hDEAD};
   logic [15:0] rt [5] = '{16'h0F0F, 16'h7FFF, 16'h5678, 16'h0001, 16'hBEEF};

   initial begin
      // Reset state.
      tick(3);
      reset = 1'b0;
      tick(2);

      // Fill the FIFO while disabled; the fifth pair must be held off.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_left = lt[i]; in_right = rt[i];
         tick(1);
      end
      tick(2);
      chk("full_ready", 0, 32'(gen[0].rdy_o), 32'd0);
      chk("full_level", 1, 32'(gen[1].lvl_o), 32'd4);

      // Enable with a pair still offered: rejected at the pop, taken next clk.
      in_left = 16'hABCD; in_right = 16'h4321;
      en = 1'b1;
      tick(300);
      in_valid = 1'b0;
      tick(1600);

      // Single push mid-frame during underruns.
      in_valid = 1'b1; in_left = 16'h8001; in_right = 16'h7FFF;
      tick(1);
      in_valid = 1'b0;
      tick(600);

      // Asynchronous reset while enabled.
      reset = 1'b1;
      #1;
      chk("rst_sck",   0, 32'(gen[0].sck_o), 32'd0);
      chk("rst_ws",    1, 32'(gen[1].ws_o),  32'd0);
      chk("rst_sd",    0, 32'(gen[0].sd_o),  32'd0);
      chk("rst_level", 1, 32'(gen[1].lvl_o), 32'd0);
      tick(2);
      reset = 1'b0;
      in_valid = 1'b1; in_left = 16'h1357; in_right = 16'h2468;
      tick(1);
      in_valid = 1'b0;
      tick(700);

      // Disable and re-enable restarts the frame.
      en = 1'b0;
      tick(10);
      in_valid = 1'b1; in_left = 16'h0F0F; in_right = 16'hF0F0;
      tick(1);
      in_valid = 1'b0;
      en = 1'b1;
      tick(600);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
